io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the 16-bit system bus IO ports between NUM_REQ requesters, such as the control unit and a debug/loader master.
- Grants one requester at a time and sequences the port strobes: io_en (rising edge loads the port from the bus) and io_out (port drives the bus).
- Guarantees no bus contention: at most one io_out high at any time, never together with an io_en.
- Captures read data internally.

Parameters:
- NUM_REQ, 2: number of requesters (1..8).
- NUM_PORTS, 2: number of IO ports controlled.
- PORT_W, 1: width of each port index; must satisfy 2**PORT_W >= NUM_PORTS.
- DATA_W, 16: bus width.
- STROBE_CYC, 1: cycles spent in the ACTIVE state (>= 1).

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester transaction request; level-sensitive.
- req_wr  in  NUM_REQ  1 = write bus into port (io_en); 0 = read port onto bus (io_out).
- req_port  in  NUM_REQ*PORT_W  flattened port index; requester i uses bits [i*PORT_W +: PORT_W].
- bus_in  in  DATA_W  observed shared bus value.
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction. A granted writer drives the bus while gnt is high.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse with done when the port index is >= NUM_PORTS.
- rd_data  out  DATA_W  data captured by the last read; valid from done, held until the next read completes.
- io_en  out  NUM_PORTS  port load strobes.
- io_out  out  NUM_PORTS  port drive enables.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE; gnt, done, err, io_en, io_out, busy, rd_data = 0; round-robin pointer = 0. Reset asserted mid-transaction drops all strobes in the same instant; the transaction is lost and no done is issued.
- IDLE:
  - If any req bit is high, select a winner: lowest index in fixed-priority mode.
  - Register the winner's gnt bit, req_wr and req_port.
  - Go to SETUP next cycle.
- SETUP (1 cycle):
  - Write: io_en = 0; the writer drives the bus so data settles.
  - Read: io_out[port] = 1.
  - Go to ACTIVE.
- ACTIVE (STROBE_CYC cycles, internal counter):
  - Write: io_en[port] = 1 for every ACTIVE cycle.
  - Read: io_out[port] stays high. On the last ACTIVE cycle, rd_data <= bus_in.
  - Go to RECOVER.
- RECOVER (1 cycle, bus turnaround/hold):
  - io_en = 0 and io_out = 0. Write data is still driven, which provides hold time after the io_en falling edge.
  - done[granted] = 1; err = 1 if port >= NUM_PORTS.
  - gnt is cleared at the end of the cycle; go to IDLE.
- Transaction latency: a req high in IDLE cycle n gives gnt at n+1 and done at n+2+STROBE_CYC.
- Back-to-back: the minimum period is 3+STROBE_CYC cycles, because IDLE is always visited for arbitration.
- Invalid port index: no io_en/io_out bit is asserted; timing is unchanged; err pulses with done.
- Requester rules:
  - req must stay high until done.
  - Dropping req mid-transaction is ignored; the transaction completes and done still pulses.
  - req still high in the IDLE after done is treated as a new request.
- req_wr and req_port are sampled only in IDLE on the grant decision; later changes have no effect.
- Invariants every cycle: popcount(gnt) <= 1; popcount(io_out) <= 1; (|io_en) & (|io_out) == 0; io_en and io_out are 0 in IDLE and RECOVER.

Optional Feature:
- IO_BUS_ARBITER_RR_EN defined:
  - Round-robin arbitration: search starts at the pointer.
  - After each done, pointer = granted index + 1, modulo NUM_REQ.
- Not defined: fixed priority, index 0 highest; no pointer register is built.

Decomposition:
- Shared package io_arb_pkg:
  - State enum: IDLE=2'd0, SETUP=2'd1, ACTIVE=2'd2, RECOVER=2'd3.
  - DATA_W default and the clog2 helper for PORT_W.
- Sub-module io_arb_pick: combinational one-hot winner select from req and the start pointer; the pointer is tied to 0 when IO_BUS_ARBITER_RR_EN is off.

Test Plan:
- Single write: req=2'b01, req_wr[0]=1, port 1, bus=16'hA5C3.
  - gnt=01 at n+1.
  - io_en=2'b10 for exactly 1 cycle at n+2.
  - done[0] at n+3; port 1 holds 16'hA5C3.
- Single read: req[1] with port 0 holding 16'h1234.
  - io_out=2'b01 in SETUP and ACTIVE.
  - rd_data=16'h1234 with done[1]; bus is Z in RECOVER.
- Contention: req=2'b11 held continuously.
  - Fixed mode: gnt=01 repeatedly; requester 1 is never granted.
  - With IO_BUS_ARBITER_RR_EN: grants alternate 01, 10, 01.
  - Invariant checkers stay clean throughout.
- Invalid index: NUM_PORTS=2, PORT_W=2, req_port=2'd3.
  - io_en and io_out stay 0.
  - done and err pulse together at n+3.
- Reset mid-op: reset driven low during ACTIVE of a write.
  - io_en, gnt and busy go 0 immediately; no done.
  - After release, a fresh request completes normally.
- STROBE_CYC=3 write: io_en high for exactly 3 cycles; done at n+5.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and helpers for the IO bus arbiter: the FSM state encoding,
// the default bus width and a constant log2 helper used for sizing indexes.
package io_arb_pkg;

  localparam int IO_ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACTIVE  = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/io_arb_pick.sv
// Combinational one-hot winner select; the search starts at ptr and wraps.
// With ptr held at 0 this is plain fixed priority, with index 0 the highest.
module io_arb_pick
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win
);

  logic             found;
  int               j;
  logic [IDX_W-1:0] j_idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IDX_W'(j);
      if (!found && req[j_idx]) begin
        win[j_idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates the shared IO port strobes between requesters: IDLE/SETUP/ACTIVE/RECOVER.
// Define IO_BUS_ARBITER_RR_EN for round-robin arbitration (default: fixed priority).
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_PORTS  = 2,
  parameter int PORT_W     = 1,
  parameter int DATA_W     = IO_ARB_DATA_W,
  parameter int STROBE_CYC = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*PORT_W-1:0] req_port,
  input  logic [DATA_W-1:0]         bus_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_PORTS-1:0]      io_en,
  output logic [NUM_PORTS-1:0]      io_out,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CNT_W = (STROBE_CYC > 1) ? clog2(STROBE_CYC) : 1;

  arb_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 txn_wr;
  logic [NUM_PORTS-1:0] txn_sel;

  logic [IDX_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   win;
  logic                 win_wr;
  logic [PORT_W-1:0]    win_port;
  logic [NUM_PORTS-1:0] win_sel;

`ifdef IO_BUS_ARBITER_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_nxt;

  assign ptr = ptr_q;

  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1);
    end
  end
`else
  assign ptr = '0;
`endif

  io_arb_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win)
  );

  // An out-of-range port index decodes to an all-zero select, which is also the error flag.
  always_comb begin
    win_wr   = 1'b0;
    win_port = '0;
    win_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_wr   = req_wr[i];
        win_port = req_port[i*PORT_W +: PORT_W];
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (win_port == PORT_W'(p)) win_sel[p] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      txn_wr  <= 1'b0;
      txn_sel <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rd_data <= '0;
      io_en   <= '0;
      io_out  <= '0;
      busy    <= 1'b0;
`ifdef IO_BUS_ARBITER_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= win;
            txn_wr  <= win_wr;
            txn_sel <= win_sel;
            io_out  <= win_wr ? '0 : win_sel;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          io_en <= txn_wr ? txn_sel : '0;
          cnt   <= CNT_W'(STROBE_CYC - 1);
          state <= ACTIVE;
        end
        ACTIVE: begin
          if (cnt == '0) begin
            io_en  <= '0;
            io_out <= '0;
            done   <= gnt;
            err    <= ~|txn_sel;
            if (!txn_wr) rd_data <= bus_in;
            state  <= RECOVER;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RECOVER: begin
          gnt   <= '0;
          busy  <= 1'b0;
`ifdef IO_BUS_ARBITER_RR_EN
          ptr_q <= ptr_nxt;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: bus/port model, done scoreboard and invariants.
// Instance a covers 2-bit port indexes (invalid index); instance b covers STROBE_CYC=3.
module tb_io_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [1:0]  req_a, req_wr_a, gnt_a, done_a, io_en_a, io_out_a;
  logic [3:0]  req_port_a;
  logic [15:0] bus_a, rd_a;
  logic        err_a, busy_a, drv_a;
  logic [15:0] wdata_a [2];
  logic [15:0] port_a [2] = '{16'h0, 16'h0};
  logic [1:0]  en_prev_a = 2'b00;

  logic [1:0]  req_b, req_wr_b, gnt_b, done_b, io_en_b, io_out_b;
  logic [1:0]  req_port_b;
  logic [15:0] bus_b, rd_b, wdata_b;
  logic        err_b, busy_b;
  logic [15:0] port_b [2] = '{16'h0, 16'h0};
  logic [1:0]  en_prev_b = 2'b00;

  io_bus_arbiter #(.NUM_REQ(2), .NUM_PORTS(2), .PORT_W(2), .DATA_W(16), .STROBE_CYC(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .req_wr(req_wr_a), .req_port(req_port_a),
    .bus_in(bus_a), .gnt(gnt_a), .done(done_a), .err(err_a), .rd_data(rd_a),
    .io_en(io_en_a), .io_out(io_out_a), .busy(busy_a)
  );

  io_bus_arbiter #(.NUM_REQ(2), .NUM_PORTS(2), .PORT_W(1), .DATA_W(16), .STROBE_CYC(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .req_wr(req_wr_b), .req_port(req_port_b),
    .bus_in(bus_b), .gnt(gnt_b), .done(done_b), .err(err_b), .rd_data(rd_b),
    .io_en(io_en_b), .io_out(io_out_b), .busy(busy_b)
  );

  // Shared-bus model: a granted writer drives, else the port whose io_out is high.
  always_comb begin
    drv_a = 1'b1;
    if (gnt_a[0] && req_wr_a[0])      bus_a = wdata_a[0];
    else if (gnt_a[1] && req_wr_a[1]) bus_a = wdata_a[1];
    else if (io_out_a[0])             bus_a = port_a[0];
    else if (io_out_a[1])             bus_a = port_a[1];
    else begin
      bus_a = 16'h0;
      drv_a = 1'b0;
    end
  end

  always_comb begin
    bus_b = (gnt_b[0] && req_wr_b[0]) ? wdata_b : 16'h0;
  end

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (io_en_a[p] && !en_prev_a[p]) port_a[p] = bus_a;
      if (io_en_b[p] && !en_prev_b[p]) port_b[p] = bus_b;
    end
    en_prev_a = io_en_a;
    en_prev_b = io_en_b;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic        chk_rd;
    logic [15:0] rd;
  } exp_t;

  exp_t sb_q[$];

  task automatic push_exp(input logic [1:0] d, input logic e, input logic c, input logic [15:0] r);
    exp_t x;
    x.done = d; x.err = e; x.chk_rd = c; x.rd = r;
    sb_q.push_back(x);
  endtask

  // Scoreboard pop on done, plus the per-cycle bus-safety invariants.
  always @(negedge clk) begin
    if (reset) begin
      exp_t e;
      check("inv_gnt_onehot", 32'($countones(gnt_a) <= 1), 1);
      check("inv_io_out_onehot", 32'($countones(io_out_a) <= 1), 1);
      check("inv_en_out_excl", 32'((|io_en_a) & (|io_out_a)), 0);
      if (!busy_a || done_a != 2'b00) check("inv_strobes_quiet", {io_en_a, io_out_a}, 0);
      if (done_a != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", done_a, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_done", done_a, e.done);
          check("sb_err", err_a, e.err);
          if (e.chk_rd) check("sb_rd_data", rd_a, e.rd);
        end
      end else begin
        check("err_without_done", err_a, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_write_a(input int r, input logic [1:0] port, input logic [15:0] d, input logic e);
    wdata_a[r] = d;
    req_wr_a[r] = 1'b1;
    req_port_a[r*2 +: 2] = port;
    req_a = 2'(1 << r);
    push_exp(2'(1 << r), e, 1'b0, 16'h0);
    tick();
    check("wr_gnt", gnt_a, 2'(1 << r));
    tick();
    tick();
    check("wr_done", done_a, 2'(1 << r));
    req_a = 2'b00;
    tick();
    check("wr_idle_gnt", gnt_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] cont_exp [3];
  int b;

  initial begin
`ifdef IO_BUS_ARBITER_RR_EN
    cont_exp = '{2'b01, 2'b10, 2'b01};
`else
    cont_exp = '{2'b01, 2'b01, 2'b01};
`endif
    reset = 1'b0;
    req_a = 2'b00; req_wr_a = 2'b00; req_port_a = 4'h0;
    wdata_a[0] = 16'h0; wdata_a[1] = 16'h0;
    req_b = 2'b00; req_wr_b = 2'b00; req_port_b = 2'b00; wdata_b = 16'h0;
    repeat (3) tick();

    check("rst_gnt", gnt_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_io_en", io_en_a, 0);
    check("rst_io_out", io_out_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rd_data", rd_a, 0);
    reset = 1'b1;
    tick();

    // preload port 0 for the read test
    run_write_a(0, 2'd0, 16'h1234, 1'b0);
    check("preload_port0", port_a[0], 16'h1234);

    // single write, port 1
    wdata_a[0] = 16'hA5C3; req_wr_a[0] = 1'b1; req_port_a[1:0] = 2'd1; req_a = 2'b01;
    push_exp(2'b01, 1'b0, 1'b0, 16'h0);
    tick();
    check("w1_gnt", gnt_a, 2'b01);
    check("w1_busy", busy_a, 1);
    check("w1_setup_io_en", io_en_a, 0);
    tick();
    check("w1_active_io_en", io_en_a, 2'b10);
    check("w1_active_done", done_a, 0);
    tick();
    check("w1_recover_io_en", io_en_a, 0);
    check("w1_done", done_a, 2'b01);
    req_a = 2'b00;
    tick();
    check("w1_idle_gnt", gnt_a, 0);
    check("w1_idle_busy", busy_a, 0);
    check("w1_port1", port_a[1], 16'hA5C3);

    // single read by requester 1 from port 0
    req_wr_a[1] = 1'b0; req_port_a[3:2] = 2'd0; req_a = 2'b10;
    push_exp(2'b10, 1'b0, 1'b1, 16'h1234);
    tick();
    check("r1_gnt", gnt_a, 2'b10);
    check("r1_setup_io_out", io_out_a, 2'b01);
    tick();
    check("r1_active_io_out", io_out_a, 2'b01);
    check("r1_active_io_en", io_en_a, 0);
    tick();
    check("r1_recover_io_out", io_out_a, 0);
    check("r1_done", done_a, 2'b10);
    check("r1_rd_data", rd_a, 16'h1234);
    check("r1_bus_released", drv_a, 0);
    req_a = 2'b00;
    tick();
    check("r1_rd_held", rd_a, 16'h1234);

    // contention with both requests held
    wdata_a[0] = 16'h1111; wdata_a[1] = 16'h2222;
    req_wr_a = 2'b11; req_port_a = {2'd1, 2'd0}; req_a = 2'b11;
    for (int t = 0; t < 3; t++) begin
      b = 0;
      while (gnt_a == 2'b00 && b < 8) begin tick(); b++; end
      check("cont_gnt_wait", 32'(b < 8), 1);
      check("cont_gnt", gnt_a, cont_exp[t]);
      push_exp(cont_exp[t], 1'b0, 1'b0, 16'h0);
      if (t == 2) req_a = 2'b00;
      b = 0;
      while (gnt_a != 2'b00 && b < 8) begin tick(); b++; end
      check("cont_release_wait", 32'(b < 8), 1);
    end
    check("cont_port0", port_a[0], 16'h1111);
`ifdef IO_BUS_ARBITER_RR_EN
    check("cont_port1", port_a[1], 16'h2222);
`else
    check("cont_port1_untouched", port_a[1], 16'hA5C3);
`endif

    // invalid port index 3
    req_wr_a[0] = 1'b1; req_port_a[1:0] = 2'd3; req_a = 2'b01;
    push_exp(2'b01, 1'b1, 1'b0, 16'h0);
    tick();
    check("inv_setup_strobes", {io_en_a, io_out_a}, 0);
    tick();
    check("inv_active_strobes", {io_en_a, io_out_a}, 0);
    tick();
    check("inv_done", done_a, 2'b01);
    check("inv_err", err_a, 1);
    req_a = 2'b00;
    tick();
    check("inv_err_cleared", err_a, 0);

    // reset asserted during ACTIVE of a write
    wdata_a[0] = 16'hBEEF; req_wr_a[0] = 1'b1; req_port_a[1:0] = 2'd0; req_a = 2'b01;
    tick();
    tick();
    check("rmid_active_io_en", io_en_a, 2'b01);
    #1 reset = 1'b0;
    req_a = 2'b00;
    #1;
    check("rmid_io_en", io_en_a, 0);
    check("rmid_gnt", gnt_a, 0);
    check("rmid_busy", busy_a, 0);
    check("rmid_rd_data", rd_a, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("rmid_no_done", done_a, 0);
    check("rmid_port0_kept", port_a[0], 16'h1111);
    run_write_a(0, 2'd0, 16'h5A5A, 1'b0);
    check("rmid_fresh_port0", port_a[0], 16'h5A5A);

    // STROBE_CYC=3 write on instance b, port 1
    wdata_b = 16'h0F0F; req_wr_b = 2'b01; req_port_b = 2'b01; req_b = 2'b01;
    tick();
    check("s3_gnt", gnt_b, 2'b01);
    check("s3_setup_io_en", io_en_b, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("s3_active_io_en", io_en_b, 2'b10);
      check("s3_active_done", done_b, 0);
    end
    tick();
    check("s3_recover_io_en", io_en_b, 0);
    check("s3_done", done_b, 2'b01);
    check("s3_err", err_b, 0);
    req_b = 2'b00;
    tick();
    check("s3_idle_gnt", gnt_b, 0);
    check("s3_port1", port_b[1], 16'h0F0F);

    repeat (3) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
